// File: rtl/chacha_block_sched.sv
// rtl/chacha_block_sched.sv - ChaCha block sequencer driving one shared quarter-round unit per clock
module chacha_block_sched #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic [3:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] qr_a,
    output logic [31:0] qr_b,
    output logic [31:0] qr_c,
    output logic [31:0] qr_d,
    input  logic [31:0] qr_ra,
    input  logic [31:0] qr_rb,
    input  logic [31:0] qr_rc,
    input  logic [31:0] qr_rd
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t      state;
    logic [31:0] in_st [16];
    logic [31:0] wk    [16];
    logic [2:0]  qi;
    logic [3:0]  dr;
    logic [3:0]  ix_a, ix_b, ix_c, ix_d;

    // qi 0..3 walk the columns, 4..7 the diagonals
    always_comb begin
        ix_a = 4'd0; ix_b = 4'd4; ix_c = 4'd8; ix_d = 4'd12;
        case (qi)
            3'd0: begin ix_a = 4'd0; ix_b = 4'd4; ix_c = 4'd8;  ix_d = 4'd12; end
            3'd1: begin ix_a = 4'd1; ix_b = 4'd5; ix_c = 4'd9;  ix_d = 4'd13; end
            3'd2: begin ix_a = 4'd2; ix_b = 4'd6; ix_c = 4'd10; ix_d = 4'd14; end
            3'd3: begin ix_a = 4'd3; ix_b = 4'd7; ix_c = 4'd11; ix_d = 4'd15; end
            3'd4: begin ix_a = 4'd0; ix_b = 4'd5; ix_c = 4'd10; ix_d = 4'd15; end
            3'd5: begin ix_a = 4'd1; ix_b = 4'd6; ix_c = 4'd11; ix_d = 4'd12; end
            3'd6: begin ix_a = 4'd2; ix_b = 4'd7; ix_c = 4'd8;  ix_d = 4'd13; end
            default: begin ix_a = 4'd3; ix_b = 4'd4; ix_c = 4'd9; ix_d = 4'd14; end
        endcase
    end

    assign qr_a    = (state == ROUND) ? wk[ix_a] : 32'd0;
    assign qr_b    = (state == ROUND) ? wk[ix_b] : 32'd0;
    assign qr_c    = (state == ROUND) ? wk[ix_c] : 32'd0;
    assign qr_d    = (state == ROUND) ? wk[ix_d] : 32'd0;
    assign rd_data = wk[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            qi    <= 3'd0;
            dr    <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                in_st[i] <= 32'd0;
                wk[i]    <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ld_en)
                        in_st[ld_addr] <= ld_data;
                    if (start) begin
                        // a same-cycle load is forwarded into the working copy
                        for (int i = 0; i < 16; i++)
                            wk[i] <= (ld_en && ld_addr == 4'(i)) ? ld_data : in_st[i];
                        qi    <= 3'd0;
                        dr    <= 4'd0;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    wk[ix_a] <= qr_ra;
                    wk[ix_b] <= qr_rb;
                    wk[ix_c] <= qr_rc;
                    wk[ix_d] <= qr_rd;
                    qi       <= qi + 3'd1;
                    if (qi == 3'd7) begin
                        dr <= dr + 4'd1;
                        if (dr == 4'(DOUBLE_ROUNDS - 1))
                            state <= FINAL;
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++)
                        wk[i] <= wk[i] + in_st[i];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
